// File: rtl/cmp_iter.sv
// Multi-cycle MSB-first magnitude comparator (unsigned or two's-complement), CHUNK bits per cycle.
// Define CMP_ITER_EARLY_EXIT_EN to leave RUN as soon as the first differing chunk is found.
module cmp_iter #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             neq,
    output logic             big_a,
    output logic             big_b
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

`ifdef CMP_ITER_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef logic [NCHUNK-1:0][CHUNK-1:0] chunks_t;

    state_t          state_q, state_d;
    chunks_t         a_q, a_d, b_q, b_d;
    logic            signed_q, signed_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            decided_q, decided_d;
    logic            gt_q, gt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            eq_q, eq_d;
    logic            neq_q, neq_d;
    logic            big_a_q, big_a_d;
    logic            big_b_q, big_b_d;
    logic [CHUNK-1:0] chunk_a, chunk_b;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        signed_d  = signed_q;
        idx_d     = idx_q;
        decided_d = decided_q;
        gt_d      = gt_q;
        done_d    = 1'b0;
        eq_d      = eq_q;
        neq_d     = neq_q;
        big_a_d   = big_a_q;
        big_b_d   = big_b_q;

        // Offset-binary on the top chunk turns the unsigned chunk order into signed order.
        chunk_a = a_q[idx_q];
        chunk_b = b_q[idx_q];
        if (signed_q && (idx_q == LAST_IDX)) begin
            chunk_a[CHUNK-1] = ~chunk_a[CHUNK-1];
            chunk_b[CHUNK-1] = ~chunk_b[CHUNK-1];
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d       = a;
                    b_d       = b;
                    signed_d  = signed_mode;
                    idx_d     = LAST_IDX;
                    decided_d = 1'b0;
                    gt_d      = 1'b0;
                    state_d   = S_RUN;
                end
            end
            S_RUN: begin
                if (!decided_q && (chunk_a != chunk_b)) begin
                    decided_d = 1'b1;
                    gt_d      = (chunk_a > chunk_b);
                end
                if ((idx_q == '0) || (EARLY_EXIT && decided_d)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                eq_d    = ~decided_q;
                neq_d   = decided_q;
                big_a_d = decided_q & gt_q;
                big_b_d = decided_q & ~gt_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            decided_q <= 1'b0;
            gt_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            eq_q      <= 1'b0;
            neq_q     <= 1'b0;
            big_a_q   <= 1'b0;
            big_b_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            decided_q <= decided_d;
            gt_q      <= gt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            eq_q      <= eq_d;
            neq_q     <= neq_d;
            big_a_q   <= big_a_d;
            big_b_q   <= big_b_d;
        end
    end

    // NOTE: operand registers have no reset; they are always loaded on accept before being read.
    always_ff @(posedge clk) begin
        a_q      <= a_d;
        b_q      <= b_d;
        signed_q <= signed_d;
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign eq    = eq_q;
    assign neq   = neq_q;
    assign big_a = big_a_q;
    assign big_b = big_b_q;

endmodule

// File: tb/tb_cmp_iter.sv
// Self-checking bench for cmp_iter (WIDTH=16, CHUNK=4): vector table, corner sequences, random vs model.
module tb_cmp_iter;

    localparam int WIDTH  = 16;
    localparam int CHUNK  = 4;
    localparam int NCHUNK = WIDTH / CHUNK;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             busy, done, eq, neq, big_a, big_b;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    cmp_iter #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .signed_mode(signed_mode),
        .busy       (busy),
        .done       (done),
        .eq         (eq),
        .neq        (neq),
        .big_a      (big_a),
        .big_b      (big_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer compare plus a count of equal leading chunks.
    function automatic int model_cmp(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic s);
        int vx, vy;
        vx = s ? int'($signed(x)) : int'(x);
        vy = s ? int'($signed(y)) : int'(y);
        if (vx > vy) return 1;
        if (vx < vy) return -1;
        return 0;
    endfunction

    function automatic int model_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int lead = 0;
        int k;
        int mask = (1 << CHUNK) - 1;
        for (int i = NCHUNK - 1; i >= 0; i--) begin
            if (((int'(x) >> (i * CHUNK)) & mask) != ((int'(y) >> (i * CHUNK)) & mask)) break;
            lead++;
        end
`ifdef CMP_ITER_EARLY_EXIT_EN
        k = (lead + 1 > NCHUNK) ? NCHUNK : lead + 1;
`else
        k = NCHUNK;
`endif
        return k + 1;
    endfunction

    task automatic wait_done(output int n);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (done) break;
        end
    endtask

    // One operation from IDLE; inputs are scrambled during RUN to prove they were latched.
    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic ts,
                          input int exp_eq, input int exp_ga, input int exp_gb, input int exp_lat,
                          input string name);
        int n;
        @(negedge clk);
        a = ta; b = tb_v; signed_mode = ts; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({name, " busy"}, int'(busy), 1);
        a = WIDTH'($urandom); b = WIDTH'($urandom); signed_mode = 1'($urandom);
        wait_done(n);
        check({name, " latency"}, n, exp_lat);
        check({name, " eq"}, int'(eq), exp_eq);
        check({name, " neq"}, int'(neq), 1 - exp_eq);
        check({name, " big_a"}, int'(big_a), exp_ga);
        check({name, " big_b"}, int'(big_b), exp_gb);
        check({name, " onehot"}, int'(eq) + int'(big_a) + int'(big_b), 1);
        @(posedge clk);
        #1;
        check({name, " done pulse"}, int'(done), 0);
    endtask

    typedef struct {
        logic [WIDTH-1:0] va;
        logic [WIDTH-1:0] vb;
        logic             vs;
        int               e_eq;
        int               e_ga;
        int               e_gb;
        int               lat_fixed;
        int               lat_early;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int n, acc, prev_acc, dones, lat, r, saw_done;
        logic [WIDTH-1:0] ra, rb;
        logic rs;

        vecs[0]  = '{16'h1234, 16'h1234, 1'b0, 1, 0, 0, 5, 5};
        vecs[1]  = '{16'h8000, 16'h7FFF, 1'b0, 0, 1, 0, 5, 2};
        vecs[2]  = '{16'h8000, 16'h7FFF, 1'b1, 0, 0, 1, 5, 2};
        vecs[3]  = '{16'h0001, 16'h0002, 1'b0, 0, 0, 1, 5, 5};
        vecs[4]  = '{16'hFFFF, 16'h8000, 1'b1, 0, 1, 0, 5, 2};
        vecs[5]  = '{16'h0000, 16'h8000, 1'b1, 0, 1, 0, 5, 2};
        vecs[6]  = '{16'h00F0, 16'h000F, 1'b0, 0, 1, 0, 5, 4};
        vecs[7]  = '{16'h0000, 16'h0000, 1'b1, 1, 0, 0, 5, 5};
        vecs[8]  = '{16'hFFFF, 16'hFFFF, 1'b0, 1, 0, 0, 5, 5};
        vecs[9]  = '{16'h7FFF, 16'hFFFF, 1'b1, 0, 1, 0, 5, 2};
        vecs[10] = '{16'h0F00, 16'h0E00, 1'b0, 0, 1, 0, 5, 3};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset eq", int'(eq), 0);
        check("reset neq", int'(neq), 0);
        check("reset big_a", int'(big_a), 0);
        check("reset big_b", int'(big_b), 0);

        foreach (vecs[i]) begin
`ifdef CMP_ITER_EARLY_EXIT_EN
            lat = vecs[i].lat_early;
`else
            lat = vecs[i].lat_fixed;
`endif
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vs, vecs[i].e_eq, vecs[i].e_ga, vecs[i].e_gb,
                   lat, $sformatf("vec%0d", i));
        end

        // Start pulsed and operands changed during RUN must be ignored.
        @(negedge clk);
        a = 16'h00F0; b = 16'h000F; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        a = 16'h0000; b = 16'hFFFF; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("midop busy", int'(busy), 1);
        wait_done(n);
        check("midop done seen", int'(done), 1);
        check("midop big_a", int'(big_a), 1);
        check("midop big_b", int'(big_b), 0);
        @(posedge clk);
        #1;
        check("midop no requeue", int'(busy), 0);

        // Reset in the second RUN cycle aborts the operation.
        @(negedge clk);
        a = 16'h1000; b = 16'h2000; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        check("abort eq", int'(eq), 0);
        check("abort neq", int'(neq), 0);
        check("abort big_a", int'(big_a), 0);
        check("abort big_b", int'(big_b), 0);
        saw_done = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done = 1;
        end
        check("abort stays idle", saw_done, 0);

        // Back-to-back with start held high.
        @(negedge clk);
        signed_mode = 1'b1; b = 16'h8000; a = 16'hFFFF; start = 1'b1;
        prev_acc = 0; dones = 0;
        for (int op = 0; op < 6; op++) begin
            lat = model_lat(a, b);
            @(posedge clk);
            #1;
            acc = cyc;
            check($sformatf("b2b%0d accept", op), int'(busy), 1);
            check($sformatf("b2b%0d single done", op), int'(done), 0);
            if (op > 0) check($sformatf("b2b%0d interval", op), acc - prev_acc, lat + 1);
            prev_acc = acc;
            a = ((op + 1) % 2 == 0) ? 16'hFFFF : 16'h0000;
            wait_done(n);
            if (done) dones++;
            check($sformatf("b2b%0d big_a", op), int'(big_a), 1);
        end
        @(negedge clk);
        start = 1'b0;
        check("b2b done count", dones, 6);
        @(posedge clk);
        @(posedge clk);

        // Random operations against the model; half share leading chunks.
        for (int i = 0; i < 200; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rs = 1'($urandom);
            if (i % 2 == 0) rb = ra ^ WIDTH'(($urandom & 32'h1) << ($urandom_range(0, WIDTH - 1)));
            if (i % 7 == 0) rb = ra;
            r = model_cmp(ra, rb, rs);
            run_op(ra, rb, rs, (r == 0) ? 1 : 0, (r > 0) ? 1 : 0, (r < 0) ? 1 : 0,
                   model_lat(ra, rb), $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
